// File: rtl/secuenciador_ecualizador_pkg.sv
// Shared definitions for the three-band equaliser sequencer and its band filter wrappers:
// FSM state encodings, gain codes and the unity-gain constant.
package secuenciador_ecualizador_pkg;

    typedef enum logic [2:0] {
        REPOSO  = 3'd0,
        HAB     = 3'd1,
        ESPERA  = 3'd2,
        CAPTURA = 3'd3,
        SUMA    = 3'd4
    } estado_t;

    localparam logic [2:0] GAN_CERO   = 3'd0;
    localparam logic [2:0] GAN_DIV8   = 3'd1;
    localparam logic [2:0] GAN_DIV4   = 3'd2;
    localparam logic [2:0] GAN_DIV2   = 3'd3;
    localparam logic [2:0] GAN_UNIDAD = 3'd4;

    localparam int NUM_BANDAS = 3;

    function automatic logic [2:0] banda_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/secuenciador_ecualizador_escalador.sv
// Per-band gain stage: combinational arithmetic shift selected by a 3-bit gain code.
// Zero latency, no flow control; codes 4..7 all pass the sample through unchanged.
module escalador_ganancia
    import secuenciador_ecualizador_pkg::*;
#(
    parameter int ancho = 25
) (
    input  logic signed [ancho-1:0] dato_i,
    input  logic        [2:0]       ganancia_i,
    output logic signed [ancho-1:0] escalado_o
);

    always_comb begin
        escalado_o = dato_i;
        case (ganancia_i)
            GAN_CERO: escalado_o = '0;
            GAN_DIV8: escalado_o = dato_i >>> 3;
            GAN_DIV4: escalado_o = dato_i >>> 2;
            GAN_DIV2: escalado_o = dato_i >>> 1;
            default:  escalado_o = dato_i;
        endcase
    end

endmodule

// File: rtl/secuenciador_ecualizador.sv
// Time-multiplexes one sample through three band filters, scales each band and sums with saturation.
// Output 3*(LAT_FILTRO+2)+2 cycles after the strobe; strobes arriving while busy are dropped and flagged.
module secuenciador_ecualizador
    import secuenciador_ecualizador_pkg::*;
#(
    parameter int ancho      = 25,
    parameter int signo      = 1,
    parameter int magnitud   = 8,
    parameter int fraccion   = 16,
    parameter int LAT_FILTRO = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    muestra_valida,
    input  logic signed [ancho-1:0] muestra_in,
    output logic signed [ancho-1:0] filtro_in,
    output logic        [2:0]       en_banda,
    input  logic signed [ancho-1:0] y_bajo,
    input  logic signed [ancho-1:0] y_medio,
    input  logic signed [ancho-1:0] y_alto,
    input  logic                    cfg_we,
    input  logic        [1:0]       cfg_banda,
    input  logic        [2:0]       cfg_ganancia,
    output logic signed [ancho-1:0] salida,
    output logic                    salida_valida,
    output logic                    ocupado,
    output logic                    sobrecarga,
    input  logic                    clr_sobrecarga
);

    localparam int CW = (LAT_FILTRO > 1) ? $clog2(LAT_FILTRO) : 1;

    // Saturation limits in the widened (ancho+2) sum domain.
    localparam logic signed [ancho+1:0] SAT_MAX = {{(2+signo){1'b0}}, {(magnitud+fraccion){1'b1}}};
    localparam logic signed [ancho+1:0] SAT_MIN = {{(2+signo){1'b1}}, {(magnitud+fraccion){1'b0}}};

    estado_t                      estado_q, estado_d;
    logic [1:0]                   idx_q, idx_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [ancho-1:0]             filtro_q, filtro_d;
    logic [ancho-1:0]             salida_q, salida_d;
    logic [2:0][ancho-1:0]        y_q, y_d;
    logic [2:0][2:0]              gan_sombra_q, gan_sombra_d;
    logic [2:0][2:0]              gan_act_q, gan_act_d;
    logic                         suma_hecha_q, suma_hecha_d;
    logic                         valida_q;
    logic                         sobre_q, sobre_d;

    logic signed [ancho-1:0]      esc_bajo, esc_medio, esc_alto;
    logic signed [ancho+1:0]      suma;
    logic [ancho-1:0]             suma_sat;

    escalador_ganancia #(.ancho(ancho)) u_esc_bajo (
        .dato_i     (y_q[0]),
        .ganancia_i (gan_act_q[0]),
        .escalado_o (esc_bajo)
    );

    escalador_ganancia #(.ancho(ancho)) u_esc_medio (
        .dato_i     (y_q[1]),
        .ganancia_i (gan_act_q[1]),
        .escalado_o (esc_medio)
    );

    escalador_ganancia #(.ancho(ancho)) u_esc_alto (
        .dato_i     (y_q[2]),
        .ganancia_i (gan_act_q[2]),
        .escalado_o (esc_alto)
    );

    always_comb begin
        suma = {{2{esc_bajo[ancho-1]}}, esc_bajo}
             + {{2{esc_medio[ancho-1]}}, esc_medio}
             + {{2{esc_alto[ancho-1]}}, esc_alto};
        if (suma > SAT_MAX) begin
            suma_sat = SAT_MAX[ancho-1:0];
        end else if (suma < SAT_MIN) begin
            suma_sat = SAT_MIN[ancho-1:0];
        end else begin
            suma_sat = suma[ancho-1:0];
        end
    end

    always_comb begin
        estado_d     = estado_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        filtro_d     = filtro_q;
        salida_d     = salida_q;
        y_d          = y_q;
        gan_act_d    = gan_act_q;
        suma_hecha_d = 1'b0;

        case (estado_q)
            REPOSO: begin
                if (muestra_valida) begin
                    filtro_d  = muestra_in;
                    gan_act_d = gan_sombra_q;
                    idx_d     = 2'd0;
                    estado_d  = HAB;
                end
            end
            HAB: begin
                cnt_d    = CW'(LAT_FILTRO - 1);
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (cnt_q == '0) begin
                    estado_d = CAPTURA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURA: begin
                case (idx_q)
                    2'd0:    y_d[0] = y_bajo;
                    2'd1:    y_d[1] = y_medio;
                    default: y_d[2] = y_alto;
                endcase
                if (idx_q < 2'd2) begin
                    idx_d    = idx_q + 2'd1;
                    estado_d = HAB;
                end else begin
                    estado_d = SUMA;
                end
            end
            SUMA: begin
                salida_d     = suma_sat;
                suma_hecha_d = 1'b1;
                estado_d     = REPOSO;
            end
            default: estado_d = REPOSO;
        endcase
    end

    // Shadow gains are writable at any time; the active copy only changes on sample acceptance.
    always_comb begin
        gan_sombra_d = gan_sombra_q;
        if (cfg_we && (cfg_banda != 2'd3)) begin
            gan_sombra_d[cfg_banda] = cfg_ganancia;
        end
    end

    always_comb begin
        sobre_d = sobre_q;
        if (clr_sobrecarga) begin
            sobre_d = 1'b0;
        end
        if (muestra_valida && (estado_q != REPOSO)) begin
            sobre_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q     <= REPOSO;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            filtro_q     <= '0;
            salida_q     <= '0;
            y_q          <= '0;
            gan_sombra_q <= {NUM_BANDAS{GAN_UNIDAD}};
            gan_act_q    <= {NUM_BANDAS{GAN_UNIDAD}};
            suma_hecha_q <= 1'b0;
            valida_q     <= 1'b0;
            sobre_q      <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            filtro_q     <= filtro_d;
            salida_q     <= salida_d;
            y_q          <= y_d;
            gan_sombra_q <= gan_sombra_d;
            gan_act_q    <= gan_act_d;
            suma_hecha_q <= suma_hecha_d;
            valida_q     <= suma_hecha_q;
            sobre_q      <= sobre_d;
        end
    end

    assign filtro_in     = filtro_q;
    assign salida        = salida_q;
    assign salida_valida = valida_q;
    assign sobrecarga    = sobre_q;
    assign ocupado       = (estado_q != REPOSO);
    assign en_banda      = (estado_q == HAB) ? banda_onehot(idx_q) : 3'b000;

endmodule

// File: tb/tb_secuenciador_ecualizador.sv
// Directed bench for secuenciador_ecualizador: expected outputs queued at stimulus time,
// popped and compared by a monitor whenever salida_valida is seen.
module tb_secuenciador_ecualizador;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              muestra_valida = 1'b0;
    logic [24:0]       muestra_in = '0;
    logic [24:0]       filtro_in;
    logic [2:0]        en_banda;
    logic [24:0]       y_bajo = '0;
    logic [24:0]       y_medio = '0;
    logic [24:0]       y_alto = '0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_banda = '0;
    logic [2:0]        cfg_ganancia = '0;
    logic [24:0]       salida;
    logic              salida_valida;
    logic              ocupado;
    logic              sobrecarga;
    logic              clr_sobrecarga = 1'b0;

    int checks = 0;
    int errors = 0;
    int ciclo  = 0;

    logic [24:0] exp_sal[$];
    int          exp_ciclo[$];
    logic [2:0]  en_log[$];
    bit          log_en = 1'b0;

    secuenciador_ecualizador dut (
        .clk            (clk),
        .reset          (reset),
        .muestra_valida (muestra_valida),
        .muestra_in     (muestra_in),
        .filtro_in      (filtro_in),
        .en_banda       (en_banda),
        .y_bajo         (y_bajo),
        .y_medio        (y_medio),
        .y_alto         (y_alto),
        .cfg_we         (cfg_we),
        .cfg_banda      (cfg_banda),
        .cfg_ganancia   (cfg_ganancia),
        .salida         (salida),
        .salida_valida  (salida_valida),
        .ocupado        (ocupado),
        .sobrecarga     (sobrecarga),
        .clr_sobrecarga (clr_sobrecarga)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] esp);
        checks++;
        if (act !== esp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nombre, act, esp);
        end
    endtask

    always @(negedge clk) begin
        if (log_en && en_banda != 3'b000) en_log.push_back(en_banda);
        if (!reset && salida_valida) begin
            if (exp_sal.size() == 0) begin
                chk("unexpected_salida_valida", 32'(salida_valida), 32'd0);
            end else begin
                chk("salida", 32'(salida), 32'(exp_sal.pop_front()));
                chk("latencia", 32'(ciclo), 32'(exp_ciclo.pop_front()));
            end
        end
    end

    task automatic muestra(input logic [24:0] m, input logic [24:0] esp, input bit con_salida);
        @(posedge clk); #1;
        muestra_in     = m;
        muestra_valida = 1'b1;
        if (con_salida) begin
            exp_sal.push_back(esp);
            exp_ciclo.push_back(ciclo + 12);
        end
        @(posedge clk); #1;
        muestra_valida = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] banda, input logic [2:0] gan);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_banda = banda; cfg_ganancia = gan;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic stubs(input logic [24:0] b, input logic [24:0] m, input logic [24:0] a);
        y_bajo = b; y_medio = m; y_alto = a;
    endtask

    task automatic limpiar_sobrecarga();
        @(posedge clk); #1 clr_sobrecarga = 1'b1;
        @(posedge clk); #1 clr_sobrecarga = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_salida", 32'(salida), 32'h0);
        chk("rst_salida_valida", 32'(salida_valida), 32'h0);
        chk("rst_en_banda", 32'(en_banda), 32'h0);
        chk("rst_filtro_in", 32'(filtro_in), 32'h0);
        chk("rst_sobrecarga", 32'(sobrecarga), 32'h0);
        chk("rst_ocupado", 32'(ocupado), 32'h0);
        reset = 1'b0;

        // Unity gains; a band-3 write must be ignored.
        stubs(25'h0008000, 25'h0004000, 25'h0002000);
        cfg(2'd3, 3'd0);
        log_en = 1'b1;
        muestra(25'h0010000, 25'h000E000, 1'b1);
        #1 chk("ocupado_tras_strobe", 32'(ocupado), 32'h1);
        chk("filtro_in_latch", 32'(filtro_in), 32'h0010000);
        repeat (14) @(posedge clk);
        log_en = 1'b0;
        chk("en_banda_pulsos", 32'(en_log.size()), 32'd3);
        if (en_log.size() == 3) begin
            chk("en_banda_0", 32'(en_log[0]), 32'h1);
            chk("en_banda_1", 32'(en_log[1]), 32'h2);
            chk("en_banda_2", 32'(en_log[2]), 32'h4);
        end

        // Saturation at both ends.
        stubs(25'h0800000, 25'h0800000, 25'h0800000);
        muestra(25'h0000001, 25'h0FFFFFF, 1'b1);
        repeat (14) @(posedge clk);
        stubs(25'h1800000, 25'h1800000, 25'h1800000);
        muestra(25'h0000002, 25'h1000000, 1'b1);
        repeat (14) @(posedge clk);
        chk("salida_retenida", 32'(salida), 32'h1000000);

        // Gains 0/2/4.
        stubs(25'h0008000, 25'h0004000, 25'h0002000);
        cfg(2'd0, 3'd0);
        cfg(2'd1, 3'd2);
        cfg(2'd2, 3'd4);
        muestra(25'h0010000, 25'h0003000, 1'b1);
        repeat (14) @(posedge clk);

        // Overrun: second strobe three cycles after the first is dropped.
        cfg(2'd0, 3'd4);
        cfg(2'd1, 3'd4);
        muestra(25'h0000AAA, 25'h000E000, 1'b1);
        @(posedge clk);
        muestra(25'h0000BBB, 25'h0, 1'b0);
        #1 chk("sobrecarga_set", 32'(sobrecarga), 32'h1);
        chk("filtro_in_retenido", 32'(filtro_in), 32'h0000AAA);
        repeat (14) @(posedge clk);
        limpiar_sobrecarga();
        chk("sobrecarga_clr", 32'(sobrecarga), 32'h0);

        // Set wins over a coincident clear.
        muestra(25'h0000CCC, 25'h000E000, 1'b1);
        @(posedge clk); #1;
        muestra_valida = 1'b1; clr_sobrecarga = 1'b1;
        @(posedge clk); #1;
        muestra_valida = 1'b0; clr_sobrecarga = 1'b0;
        chk("sobrecarga_set_gana", 32'(sobrecarga), 32'h1);
        repeat (14) @(posedge clk);
        limpiar_sobrecarga();
        chk("sobrecarga_clr2", 32'(sobrecarga), 32'h0);

        // Shadow write during ESPERA must not touch the sample in flight.
        muestra(25'h0010000, 25'h000E000, 1'b1);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_banda = 2'd1; cfg_ganancia = 3'd0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        repeat (14) @(posedge clk);
        muestra(25'h0010000, 25'h000A000, 1'b1);
        repeat (14) @(posedge clk);

        // Reset during CAPTURA aborts the sequence.
        muestra(25'h0012345, 25'h0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        chk("ocupado_antes_reset", 32'(ocupado), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rr_salida", 32'(salida), 32'h0);
        chk("rr_salida_valida", 32'(salida_valida), 32'h0);
        chk("rr_en_banda", 32'(en_banda), 32'h0);
        chk("rr_filtro_in", 32'(filtro_in), 32'h0);
        chk("rr_ocupado", 32'(ocupado), 32'h0);
        chk("rr_sobrecarga", 32'(sobrecarga), 32'h0);
        reset = 1'b0;
        repeat (14) @(posedge clk);
        muestra(25'h0010000, 25'h000E000, 1'b1);
        repeat (14) @(posedge clk);

        chk("salidas_pendientes", 32'(exp_sal.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
